quadrature_decoder: RTL and testbench

- Decodes a two-phase quadrature source (ChA/ChB) into single-cycle Up/Down step strobes.
- Maintains a wrapping position count with full and empty flags.
- Acts as the command-generating end for the team's up/down counter: its Up/Down outputs are one-cycle strobes that can drive counter Up/Down/Enable directly.
- Sits between off-chip encoder pins and the position/counter logic.

---
 rtl/quad_pkg.sv | 48 ++++
 rtl/quad_input_filter.sv | 89 ++++++++
 rtl/quadrature_decoder.sv | 114 +++++++++++
 tb/tb_quadrature_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
`default_nettype none
// ============================================================================
// Package  : quad_pkg
// Brief    : Shared phase encoding, step directions and the step classifier
//            used by the quadrature decoder.
// Revision : 1.0 - initial release
// ============================================================================
package quad_pkg;

  // Phase states are the filtered {A,B} pair itself
  typedef enum logic [1:0] {
    P00 = 2'b00,
    P01 = 2'b01,
    P10 = 2'b10,
    P11 = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    DIR_NONE    = 2'd0,
    DIR_UP      = 2'd1,
    DIR_DOWN    = 2'd2,
    DIR_ILLEGAL = 2'd3
  } dir_t;

  // Position of a phase along the forward cycle P00->P10->P11->P01
  function automatic logic [1:0] phase_pos(input phase_t p);
    case (p)
      P00:     return 2'd0;
      P10:     return 2'd1;
      P11:     return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Distance along the cycle: +1 forward, -1 reverse, 2 is a diagonal jump
  function automatic dir_t step_dir(input phase_t prev, input phase_t next);
    logic [1:0] delta;
    delta = phase_pos(next) - phase_pos(prev);
    case (delta)
      2'd0:    return DIR_NONE;
      2'd1:    return DIR_UP;
      2'd3:    return DIR_DOWN;
      default: return DIR_ILLEGAL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_input_filter.sv
`default_nettype none
// ============================================================================
// Module   : quad_input_filter
// Brief    : Synchronizes the ChA/ChB pair and accepts a level only after it
//            has been stable for FILTER_LEN cycles; pulses update on accept.
// Revision : 1.0 - initial release
// ============================================================================
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       Clock,
  input  logic       ResetN,
  input  logic       ChA,
  input  logic       ChB,
  output logic [1:0] filtered,
  output logic       update
);

  localparam int                 c_RUN_W   = $clog2(FILTER_LEN + 1);
  localparam logic [c_RUN_W-1:0] c_RUN_MAX = c_RUN_W'(FILTER_LEN);
  localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);

  logic [SYNC_STAGES-1:0][1:0] r_sync;
  logic [SYNC_STAGES-1:0]      r_valid;
  logic [1:0]                  r_cand;
  logic [c_RUN_W-1:0]          r_run;
  logic [1:0]                  r_filtered;
  logic                        r_update;

  logic [1:0]         w_sync;
  logic               w_valid;
  logic               w_changed;
  logic [c_RUN_W-1:0] w_runNext;
  logic               w_fire;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  // Run counting only starts once real pin samples reach the end of the chain,
  // so stable pins at reset release are accepted after SYNC_STAGES+FILTER_LEN.
  assign w_valid = r_valid[SYNC_STAGES-1];

  // Synchronizer chain plus a matching valid marker shifting in behind reset
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_sync  <= '0;
      r_valid <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], {ChA, ChB}};
      r_valid <= {r_valid[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Stability run length; fires once when the run first reaches FILTER_LEN
  always_comb begin
    w_changed = (w_sync != r_cand);
    w_runNext = r_run;
    if (w_changed) begin
      w_runNext = c_RUN_ONE;
    end else if (r_run != c_RUN_MAX) begin
      w_runNext = r_run + c_RUN_ONE;
    end
    w_fire = w_valid && (w_runNext == c_RUN_MAX) && (w_changed || (r_run != c_RUN_MAX));
  end

  // Candidate/run registers and the accepted phase with its update pulse
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_cand     <= 2'b00;
      r_run      <= '0;
      r_filtered <= 2'b00;
      r_update   <= 1'b0;
    end else if (!w_valid) begin
      r_run    <= '0;
      r_update <= 1'b0;
    end else begin
      r_cand   <= w_sync;
      r_run    <= w_runNext;
      r_update <= w_fire;
      if (w_fire) begin
        r_filtered <= w_sync;
      end
    end
  end

  assign filtered = r_filtered;
  assign update   = r_update;

endmodule
`default_nettype wire

// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : quadrature_decoder
// Brief    : Quadrature phase tracker producing one-cycle Up/Down strobes,
//            a wrapping position count, full/empty flags and a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int BITS        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic            Clock,
  input  logic            ResetN,
  input  logic            Enable,
  input  logic            Clear,
  input  logic            ChA,
  input  logic            ChB,
  output logic            Up,
  output logic            Down,
  output logic [BITS-1:0] Count,
  output logic            FullFlag,
  output logic            EmptyFlag,
  output logic            Error
);

  logic [1:0] w_filtered;
  logic       w_update;

  phase_t          r_phase,  w_phaseNext;
  logic            r_primed, w_primedNext;
  logic            r_up,     w_upNext;
  logic            r_down,   w_downNext;
  logic [BITS-1:0] r_count,  w_countNext;
  logic            r_error,  w_errorNext;
  dir_t            w_dir;

  quad_input_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_filter (
    .Clock    (Clock),
    .ResetN   (ResetN),
    .ChA      (ChA),
    .ChB      (ChB),
    .filtered (w_filtered),
    .update   (w_update)
  );

  // State register for phase, priming, strobes, count and error
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_phase  <= P00;
      r_primed <= 1'b0;
      r_up     <= 1'b0;
      r_down   <= 1'b0;
      r_count  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_phase  <= w_phaseNext;
      r_primed <= w_primedNext;
      r_up     <= w_upNext;
      r_down   <= w_downNext;
      r_count  <= w_countNext;
      r_error  <= w_errorNext;
    end
  end

  // Classify each accepted phase change; Clear overrides count and error last
  always_comb begin
    w_phaseNext  = r_phase;
    w_primedNext = r_primed;
    w_upNext     = 1'b0;
    w_downNext   = 1'b0;
    w_countNext  = r_count;
    w_errorNext  = r_error;
    w_dir        = DIR_NONE;
    if (w_update) begin
      // The first accepted phase after reset only seeds the tracker
      w_phaseNext  = phase_t'(w_filtered);
      w_primedNext = 1'b1;
      if (r_primed) begin
        w_dir = step_dir(r_phase, phase_t'(w_filtered));
      end
    end
    if (Enable) begin
      w_upNext   = (w_dir == DIR_UP);
      w_downNext = (w_dir == DIR_DOWN);
    end
    if (w_upNext) begin
      w_countNext = r_count + BITS'(1);
    end else if (w_downNext) begin
      w_countNext = r_count - BITS'(1);
    end
    if (w_dir == DIR_ILLEGAL) begin
      w_errorNext = 1'b1;
    end
    if (Clear) begin
      w_countNext = '0;
      w_errorNext = 1'b0;
    end
  end

  assign Up        = r_up;
  assign Down      = r_down;
  assign Count     = r_count;
  assign Error     = r_error;
  assign FullFlag  = &r_count;
  assign EmptyFlag = ~|r_count;

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_quadrature_decoder
// Brief    : Self-checking bench for quadrature_decoder with a cycle-position
//            reference model of the encoder and expected strobe tallies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_quadrature_decoder;

  localparam int BITS = 4;
  localparam int MOD  = 1 << BITS;

  logic            Clock = 1'b0;
  logic            ResetN, Enable, Clear, ChA, ChB;
  logic            Up, Down, FullFlag, EmptyFlag, Error;
  logic [BITS-1:0] Count;

  int nChecks = 0;
  int nPass   = 0;

  // Observed strobe tallies
  int   upSeen = 0, downSeen = 0, bothSeen = 0, fullRise = 0;
  logic prevFull = 1'b0;

  // Reference model: phase as a position on the forward cycle
  int         refCount = 0, refUps = 0, refDowns = 0;
  bit         refError = 1'b0, refPrimed = 1'b0;
  logic [1:0] refPhase = 2'b00;
  logic [1:0] cycleSeq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quadrature_decoder #(.BITS(BITS), .SYNC_STAGES(2), .FILTER_LEN(3)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .Enable    (Enable),
    .Clear     (Clear),
    .ChA       (ChA),
    .ChB       (ChB),
    .Up        (Up),
    .Down      (Down),
    .Count     (Count),
    .FullFlag  (FullFlag),
    .EmptyFlag (EmptyFlag),
    .Error     (Error)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (Up) upSeen++;
    if (Down) downSeen++;
    if (Up && Down) bothSeen++;
    if (FullFlag && !prevFull) fullRise++;
    prevFull = FullFlag;
  end

  function automatic int pos_of(input logic [1:0] p);
    for (int i = 0; i < 4; i++) if (cycleSeq[i] == p) return i;
    return 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
    #1;
  endtask

  task automatic model_step(input logic a, input logic b);
    logic [1:0] np;
    int d;
    np = {a, b};
    if (!refPrimed) begin
      refPrimed = 1'b1;
      refPhase  = np;
      return;
    end
    d = (pos_of(np) - pos_of(refPhase) + 4) % 4;
    if (d == 2) refError = 1'b1;
    else if (Enable && d == 1) begin refCount = (refCount + 1) % MOD; refUps++; end
    else if (Enable && d == 3) begin refCount = (refCount + MOD - 1) % MOD; refDowns++; end
    refPhase = np;
  endtask

  task automatic drive_phase(input logic a, input logic b, input int hold);
    model_step(a, b);
    ChA = a;
    ChB = b;
    tick(hold);
  endtask

  task automatic step_fwd(input int hold);
    logic [1:0] np;
    np = cycleSeq[(pos_of(refPhase) + 1) % 4];
    drive_phase(np[1], np[0], hold);
  endtask

  task automatic step_rev(input int hold);
    logic [1:0] np;
    np = cycleSeq[(pos_of(refPhase) + 3) % 4];
    drive_phase(np[1], np[0], hold);
  endtask

  task automatic pulse_clear();
    Clear = 1'b1;
    tick(1);
    Clear = 1'b0;
    refCount = 0;
    refError = 1'b0;
  endtask

  task automatic test_reset();
    ResetN = 1'b0; Enable = 1'b1; Clear = 1'b0; ChA = 1'b0; ChB = 1'b0;
    tick(3);
    nChecks++; if (Count !== '0) $display("FAIL reset_count: got %0d want 0", Count); else nPass++;
    nChecks++; if (EmptyFlag !== 1'b1 || FullFlag !== 1'b0) $display("FAIL reset_flags: got empty=%b full=%b want 1/0", EmptyFlag, FullFlag); else nPass++;
    nChecks++; if (Up !== 1'b0 || Down !== 1'b0 || Error !== 1'b0) $display("FAIL reset_outs: got up=%b down=%b err=%b want 0", Up, Down, Error); else nPass++;
    ResetN = 1'b1;
    tick(10);
    refPrimed = 1'b1;
    refPhase  = {ChA, ChB};
    nChecks++; if (Count !== BITS'(refCount) || EmptyFlag !== 1'b1) $display("FAIL prime_count: got %0d empty=%b want %0d empty=1", Count, EmptyFlag, refCount); else nPass++;
    nChecks++; if (upSeen != refUps || downSeen != refDowns) $display("FAIL prime_strobes: got up=%0d down=%0d want %0d/%0d", upSeen, downSeen, refUps, refDowns); else nPass++;
  endtask

  task automatic test_latency();
    model_step(1'b1, 1'b0);
    ChA = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      nChecks++; if (Up !== (k == 6)) $display("FAIL latency_up_edge%0d: got %b want %b", k, Up, (k == 6)); else nPass++;
      if (k == 6) begin
        nChecks++; if (Count !== BITS'(refCount)) $display("FAIL latency_count: got %0d want %0d", Count, refCount); else nPass++;
      end
    end
  endtask

  task automatic test_forward_reverse();
    int fr0;
    pulse_clear();
    fr0 = fullRise;
    repeat (20) step_fwd(8);
    nChecks++; if (Count !== BITS'(refCount)) $display("FAIL fwd20_count: got %0d want %0d", Count, refCount); else nPass++;
    nChecks++; if (fullRise - fr0 != 1) $display("FAIL fwd20_full: got %0d full events want 1", fullRise - fr0); else nPass++;
    repeat (20) step_rev(8);
    nChecks++; if (Count !== BITS'(refCount) || EmptyFlag !== (refCount == 0)) $display("FAIL rev20_count: got %0d empty=%b want %0d", Count, EmptyFlag, refCount); else nPass++;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(1, 0) == 1) step_fwd($urandom_range(10, 7));
      else step_rev($urandom_range(10, 7));
      nChecks++; if (Count !== BITS'(refCount) || FullFlag !== (refCount == MOD - 1) || EmptyFlag !== (refCount == 0))
        $display("FAIL walk_count_%0d: got %0d full=%b empty=%b want %0d", i, Count, FullFlag, EmptyFlag, refCount); else nPass++;
    end
    nChecks++; if (upSeen != refUps || downSeen != refDowns) $display("FAIL walk_strobes: got up=%0d down=%0d want %0d/%0d", upSeen, downSeen, refUps, refDowns); else nPass++;
  endtask

  task automatic test_glitch();
    for (int g = 0; g < 3 && refPhase != 2'b00; g++) step_fwd(8);
    for (int i = 0; i < 4; i++) begin
      int len;
      bit onA;
      len = $urandom_range(2, 1);
      onA = ($urandom_range(1, 0) == 1);
      if (onA) ChA = ~ChA; else ChB = ~ChB;
      tick(len);
      if (onA) ChA = ~ChA; else ChB = ~ChB;
      tick(12);
      nChecks++; if (Count !== BITS'(refCount) || upSeen != refUps || downSeen != refDowns)
        $display("FAIL glitch_%0d: got count=%0d up=%0d down=%0d want %0d/%0d/%0d", i, Count, upSeen, downSeen, refCount, refUps, refDowns); else nPass++;
    end
    model_step(refPhase[1], ~refPhase[0]);
    ChB = ~ChB;
    tick(3);
    model_step(refPhase[1], ~refPhase[0]);
    ChB = ~ChB;
    tick(12);
    nChecks++; if (Count !== BITS'(refCount) || upSeen != refUps || downSeen != refDowns)
      $display("FAIL pulse3: got count=%0d up=%0d down=%0d want %0d/%0d/%0d", Count, upSeen, downSeen, refCount, refUps, refDowns); else nPass++;
  endtask

  task automatic test_illegal();
    logic [1:0] np;
    np = refPhase ^ 2'b11;
    drive_phase(np[1], np[0], 10);
    nChecks++; if (Error !== refError) $display("FAIL diag_error: got %b want %b", Error, refError); else nPass++;
    nChecks++; if (Count !== BITS'(refCount) || upSeen != refUps || downSeen != refDowns)
      $display("FAIL diag_nostrobe: got count=%0d up=%0d down=%0d want %0d/%0d/%0d", Count, upSeen, downSeen, refCount, refUps, refDowns); else nPass++;
    step_fwd(8);
    nChecks++; if (Error !== refError || Count !== BITS'(refCount)) $display("FAIL diag_sticky: got err=%b count=%0d want %b/%0d", Error, Count, refError, refCount); else nPass++;
    pulse_clear();
    nChecks++; if (Error !== 1'b0 || Count !== '0) $display("FAIL diag_clear: got err=%b count=%0d want 0/0", Error, Count); else nPass++;
  endtask

  task automatic test_enable_clear();
    logic [1:0] np;
    step_fwd(8);
    Enable = 1'b0;
    repeat (3) step_fwd(8);
    nChecks++; if (Count !== BITS'(refCount) || upSeen != refUps) $display("FAIL enable_hold: got count=%0d up=%0d want %0d/%0d", Count, upSeen, refCount, refUps); else nPass++;
    Enable = 1'b1;
    np = cycleSeq[(pos_of(refPhase) + 1) % 4];
    model_step(np[1], np[0]);
    ChA = np[1]; ChB = np[0];
    tick(5);
    Clear = 1'b1;
    tick(1);
    Clear = 1'b0;
    refCount = 0;
    nChecks++; if (Up !== 1'b1 || Count !== '0) $display("FAIL clear_on_step: got up=%b count=%0d want 1/0", Up, Count); else nPass++;
    tick(2);
    nChecks++; if (Count !== '0 || Up !== 1'b0) $display("FAIL clear_after: got count=%0d up=%b want 0/0", Count, Up); else nPass++;
    np = refPhase ^ 2'b11;
    model_step(np[1], np[0]);
    ChA = np[1]; ChB = np[0];
    tick(5);
    Clear = 1'b1;
    tick(1);
    Clear = 1'b0;
    refCount = 0;
    refError = 1'b0;
    tick(3);
    nChecks++; if (Error !== refError) $display("FAIL clear_diag: got err=%b want %b", Error, refError); else nPass++;
  endtask

  task automatic test_async_reset();
    pulse_clear();
    repeat (9) step_fwd(8);
    nChecks++; if (Count !== BITS'(refCount)) $display("FAIL pre_reset_count: got %0d want %0d", Count, refCount); else nPass++;
    #2 ResetN = 1'b0;
    #1;
    refCount = 0; refError = 1'b0; refPrimed = 1'b0;
    nChecks++; if (Count !== '0 || Up !== 1'b0 || Down !== 1'b0 || EmptyFlag !== 1'b1)
      $display("FAIL async_reset: got count=%0d up=%b down=%b empty=%b want 0/0/0/1", Count, Up, Down, EmptyFlag); else nPass++;
    tick(2);
    ResetN = 1'b1;
    tick(10);
    refPrimed = 1'b1;
    refPhase  = {ChA, ChB};
    nChecks++; if (upSeen != refUps || downSeen != refDowns) $display("FAIL reprime_strobes: got up=%0d down=%0d want %0d/%0d", upSeen, downSeen, refUps, refDowns); else nPass++;
    step_fwd(8);
    nChecks++; if (Count !== BITS'(refCount)) $display("FAIL reprime_count: got %0d want %0d", Count, refCount); else nPass++;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_forward_reverse();
    test_glitch();
    test_illegal();
    test_enable_clear();
    test_async_reset();
    nChecks++; if (bothSeen != 0) $display("FAIL up_down_overlap: got %0d cycles want 0", bothSeen); else nPass++;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
